bvsle_bvor_skolem_seq: RTL and testbench
========================================

BVSLE_BVOR_SKOLEM_SEQ -- requirements
Module: bvsle_bvor_skolem_seq

Interface
REQ-001 SHALL provide parameter W, default 4, meaning operand/witness width in bits (legal W >= 2).
REQ-002 SHALL provide parameter SIGNED_CMP, default 1, meaning comparison mode: 1 = signed (bvsle), 0 = unsigned (bvule).
REQ-003 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 SHALL have port in_valid  input  1  request carries valid operands.
REQ-006 SHALL have port in_ready  output  1  block can accept a request.
REQ-007 SHALL have port in_a  input  W  constant operand a in constraint (a | x) <= b.
REQ-008 SHALL have port in_b  input  W  bound operand b.
REQ-009 SHALL have port out_valid  output  1  result available.
REQ-010 SHALL have port out_ready  input  1  consumer accepts result.
REQ-011 SHALL have port out_x  output  W  Skolem witness x.
REQ-012 SHALL have port out_sat  output  1  1 = some x satisfies constraint.

Function
REQ-013 SHALL implement a three-state machine: IDLE, RUN, DONE.
REQ-014 SHALL drive in_ready = 1 exactly in IDLE; out_valid = 1 exactly in DONE.
REQ-015 SHALL, on accept (in_valid & in_ready at a clock edge), latch in_a/in_b, clear the x register, set bit index to W-1, and compute sat = cmp(in_a | 2^(W-1), in_b) in signed mode or cmp(in_a, in_b) in unsigned mode.
REQ-016 SHALL go from IDLE to RUN when sat = 1, and straight to DONE with out_x = 0, out_sat = 0 when sat = 0 (latency 1 edge).
REQ-017 SHALL, in RUN, decide one bit per cycle, MSB first: bit i of x = 1 iff cmp(a | x_prefix | 2^i, b) holds, x_prefix being already-decided higher bits with all lower bits zero.
REQ-018 SHALL move RUN to DONE on the edge that decides bit 0; sat latency = W+1 edges from accept to out_valid visible.
REQ-019 SHALL hold out_x and out_sat stable while out_valid = 1 and out_ready = 0.
REQ-020 SHALL move DONE to IDLE on out_valid & out_ready; no new request is accepted in that same cycle.
REQ-021 SHALL ignore in_valid and changes to in_a/in_b outside IDLE.
REQ-022 SHALL guarantee, when out_sat = 1, that (a | out_x) <= b under the selected comparison, and that out_x is the unsigned-maximal such witness.
REQ-023 SHALL treat cmp as W-bit two's-complement <= (SIGNED_CMP=1) or unsigned <= (SIGNED_CMP=0), with no width extension beyond W+1 internally.

Reset
REQ-024 SHALL, while rst_n = 0, force state IDLE, out_x = 0, out_sat = 0, out_valid = 0, in_ready = 1 after release, bit index = W-1.
REQ-025 SHALL abandon any in-flight RUN/DONE transaction on reset without emitting a result.

Structure
REQ-026 SHALL place the state enum (IDLE, RUN, DONE) in shared package bvsle_skolem_pkg.
REQ-027 SHALL implement the comparator as one sub-module bv_le_cmp (parameters W, SIGNED_CMP; inputs lhs, rhs; output le), instantiated once for the per-bit test and once for the accept-time sat test.

Verification
REQ-028 SHALL cover W=4 signed, a=0000, b=0000 -> out_sat=1, out_x=1111, out_valid 5 edges after accept.
REQ-029 SHALL cover W=4 signed, a=0001, b=1011 -> out_sat=1, out_x=1011.
REQ-030 SHALL cover W=4 signed, a=0101, b=1010 -> out_sat=0, out_x=0000, out_valid 1 edge after accept.
REQ-031 SHALL cover W=4 unsigned, a=0010, b=0110 -> out_sat=1, out_x=0110.
REQ-032 SHALL cover backpressure: out_ready held 0 for 3 cycles in DONE -> out_x/out_sat stable, in_ready=0; then out_ready=1 -> IDLE next edge.
REQ-033 SHALL cover rst_n pulsed low mid-RUN -> outputs at reset values, next request (a=0000, b=0000) yields out_x=1111 with normal latency.

Source files
------------

// File: rtl/bvsle_skolem_pkg.sv
// bvsle_skolem_pkg: shared state encoding and sizing helper for the Skolem witness search.
//   state_t      : controller states IDLE / RUN / DONE
//   idx_width(w) : bits needed to hold a bit index 0..w-1
package bvsle_skolem_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    function automatic int idx_width(input int w);
        return (w > 2) ? $clog2(w) : 1;
    endfunction

endpackage

// File: rtl/bv_le_cmp.sv
// bv_le_cmp: W-bit less-or-equal comparator, two's-complement or unsigned.
//   lhs, rhs : W-bit operands
//   le       : 1 when lhs <= rhs in the selected ordering
module bv_le_cmp #(
    parameter int W          = 4,
    parameter bit SIGNED_CMP = 1'b1
) (
    input  logic [W-1:0] lhs,
    input  logic [W-1:0] rhs,
    output logic         le
);

    logic [W-1:0] w_lhs;
    logic [W-1:0] w_rhs;

    // Flipping the sign bit maps two's-complement order onto unsigned order.
    assign w_lhs = {lhs[W-1] ^ SIGNED_CMP, lhs[W-2:0]};
    assign w_rhs = {rhs[W-1] ^ SIGNED_CMP, rhs[W-2:0]};
    assign le    = (w_lhs <= w_rhs);

endmodule

// File: rtl/bvsle_bvor_skolem_seq.sv
// bvsle_bvor_skolem_seq: finds the unsigned-maximal x with (a | x) <= b, one bit per cycle, MSB first.
//   clk, rst_n           : clock, asynchronous active-low reset
//   in_valid/in_ready    : request handshake carrying in_a, in_b
//   out_valid/out_ready  : result handshake carrying out_x (witness) and out_sat
module bvsle_bvor_skolem_seq
    import bvsle_skolem_pkg::*;
#(
    parameter int W          = 4,
    parameter bit SIGNED_CMP = 1'b1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_a,
    input  logic [W-1:0] in_b,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_x,
    output logic         out_sat
);

    localparam int           IW       = idx_width(W);
    localparam logic [W-1:0] SIGN_BIT = {1'b1, {(W-1){1'b0}}};

    state_t         r_state;
    state_t         w_next;
    logic [W-1:0]   r_a;
    logic [W-1:0]   r_b;
    logic [W-1:0]   r_x;
    logic           r_sat;
    logic [IW-1:0]  r_idx;

    logic [W-1:0]   w_bit;
    logic [W-1:0]   w_try_x;
    logic [W-1:0]   w_try_lhs;
    logic [W-1:0]   w_acc_lhs;
    logic           w_try_le;
    logic           w_acc_le;
    logic           w_accept;
    logic           w_last;

    assign w_bit     = W'(1) << r_idx;
    assign w_try_x   = r_x | w_bit;
    assign w_try_lhs = r_a | w_try_x;
    // Smallest reachable (a | x): signed sets the sign bit, unsigned leaves a untouched.
    assign w_acc_lhs = SIGNED_CMP ? (in_a | SIGN_BIT) : in_a;
    assign w_accept  = in_valid & in_ready;
    assign w_last    = (r_idx == '0);

    bv_le_cmp #(.W(W), .SIGNED_CMP(SIGNED_CMP)) u_try_cmp (
        .lhs (w_try_lhs),
        .rhs (r_b),
        .le  (w_try_le)
    );

    bv_le_cmp #(.W(W), .SIGNED_CMP(SIGNED_CMP)) u_acc_cmp (
        .lhs (w_acc_lhs),
        .rhs (in_b),
        .le  (w_acc_le)
    );

    always_comb begin
        w_next    = r_state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) w_next = w_acc_le ? S_RUN : S_DONE;
            end
            S_RUN:  if (w_last) w_next = S_DONE;
            S_DONE: begin
                out_valid = 1'b1;
                if (out_ready) w_next = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_a     <= '0;
            r_b     <= '0;
            r_x     <= '0;
            r_sat   <= 1'b0;
            r_idx   <= IW'(W-1);
        end else begin
            r_state <= w_next;
            if (w_accept) begin
                r_a   <= in_a;
                r_b   <= in_b;
                r_x   <= '0;
                r_sat <= w_acc_le;
                r_idx <= IW'(W-1);
            end else if (r_state == S_RUN) begin
                // Lower bits are still zero, so keeping the bit is safe exactly when the test passes.
                if (w_try_le) r_x <= w_try_x;
                if (!w_last) r_idx <= r_idx - IW'(1);
            end
        end
    end

    assign out_x   = r_x;
    assign out_sat = r_sat;

endmodule

// File: tb/tb_bvsle_bvor_skolem_seq.sv
// tb_bvsle_bvor_skolem_seq: scoreboard bench, instance 0 signed and instance 1 unsigned, W=4.
module tb_bvsle_bvor_skolem_seq;

    localparam int W = 4;
    localparam int N = 1 << W;

    typedef struct {
        logic [W-1:0] x;
        logic         s;
        int           acc;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst_n     [2];
    logic         in_valid  [2];
    logic         in_ready  [2];
    logic [W-1:0] in_a      [2];
    logic [W-1:0] in_b      [2];
    logic         out_valid [2];
    logic         out_ready [2] = '{1'b0, 1'b0};
    logic [W-1:0] out_x     [2];
    logic         out_sat   [2];

    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;
    int   rmode  [2] = '{0, 0};
    bit   seen   [2] = '{1'b0, 1'b0};
    exp_t q      [2][$];

    bvsle_bvor_skolem_seq #(.W(W), .SIGNED_CMP(1'b1)) u_dut_s (
        .clk       (clk),
        .rst_n     (rst_n[0]),
        .in_valid  (in_valid[0]),
        .in_ready  (in_ready[0]),
        .in_a      (in_a[0]),
        .in_b      (in_b[0]),
        .out_valid (out_valid[0]),
        .out_ready (out_ready[0]),
        .out_x     (out_x[0]),
        .out_sat   (out_sat[0])
    );

    bvsle_bvor_skolem_seq #(.W(W), .SIGNED_CMP(1'b0)) u_dut_u (
        .clk       (clk),
        .rst_n     (rst_n[1]),
        .in_valid  (in_valid[1]),
        .in_ready  (in_ready[1]),
        .in_a      (in_a[1]),
        .in_b      (in_b[1]),
        .out_valid (out_valid[1]),
        .out_ready (out_ready[1]),
        .out_x     (out_x[1]),
        .out_sat   (out_sat[1])
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic int val(input bit sg, input logic [W-1:0] v);
        return sg ? int'($signed(v)) : int'(v);
    endfunction

    // Exhaustive search: the last satisfying x in ascending order is the unsigned maximum.
    function automatic void model(input bit sg, input logic [W-1:0] a, input logic [W-1:0] b,
                                  output logic [W-1:0] x, output logic s);
        logic [W-1:0] v;
        x = '0;
        s = 1'b0;
        for (int i = 0; i < N; i++) begin
            v = W'(i);
            if (val(sg, a | v) <= val(sg, b)) begin
                s = 1'b1;
                x = v;
            end
        end
    endfunction

    task automatic check(input int m, input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s inst=%0d actual=%0d required=%0d t=%0t", name, m, act, req, $time);
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        bit   r;
        for (int m = 0; m < 2; m++) begin
            if (!rst_n[m]) begin
                q[m].delete();
                seen[m]      = 1'b0;
                out_ready[m] = 1'b0;
            end else begin
                r = (rmode[m] == 0) ? 1'($urandom % 2) : (rmode[m] == 2);
                if (out_valid[m]) begin
                    if (q[m].size() == 0) begin
                        check(m, "unexpected_out", 1, 0);
                    end else begin
                        e = q[m][0];
                        check(m, "out_x", int'(out_x[m]), int'(e.x));
                        check(m, "out_sat", int'(out_sat[m]), int'(e.s));
                        if (!seen[m]) begin
                            check(m, "latency", cyc - e.acc, e.s ? W + 1 : 1);
                            check(m, "in_ready_done", int'(in_ready[m]), 0);
                            seen[m] = 1'b1;
                        end
                        if (r) begin
                            void'(q[m].pop_front());
                            seen[m] = 1'b0;
                        end
                    end
                end
                out_ready[m] = r;
            end
        end
    end

    task automatic send(input int m, input logic [W-1:0] a, input logic [W-1:0] b);
        exp_t e;
        int   n;
        n = 0;
        @(negedge clk);
        in_valid[m] = 1'b1;
        in_a[m]     = a;
        in_b[m]     = b;
        while (!in_ready[m] && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready[m]) begin
            check(m, "accept_timeout", 0, 1);
            in_valid[m] = 1'b0;
            return;
        end
        model(m == 0, a, b, e.x, e.s);
        e.acc = cyc;
        q[m].push_back(e);
        @(negedge clk);
        in_valid[m] = 1'b0;
        in_a[m]     = W'($urandom);
        in_b[m]     = W'($urandom);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((q[0].size() != 0 || q[1].size() != 0) && n < 1000) begin
            @(negedge clk);
            n++;
        end
        check(0, "drain", q[0].size() + q[1].size(), 0);
    endtask

    initial begin
        int n;
        rst_n    = '{1'b0, 1'b0};
        in_valid = '{1'b0, 1'b0};
        in_a     = '{4'd0, 4'd0};
        in_b     = '{4'd0, 4'd0};
        #2;
        for (int m = 0; m < 2; m++) begin
            check(m, "rst_out_valid", int'(out_valid[m]), 0);
            check(m, "rst_out_x", int'(out_x[m]), 0);
            check(m, "rst_out_sat", int'(out_sat[m]), 0);
        end
        repeat (2) @(negedge clk);
        #2 rst_n = '{1'b1, 1'b1};
        #1;
        for (int m = 0; m < 2; m++) check(m, "rst_in_ready", int'(in_ready[m]), 1);

        send(0, 4'b0000, 4'b0000);
        send(0, 4'b0001, 4'b1011);
        send(0, 4'b0101, 4'b1010);
        send(1, 4'b0010, 4'b0110);
        drain();

        rmode[0] = 1;
        send(0, 4'b0001, 4'b1011);
        n = 0;
        while (!out_valid[0] && n < 50) begin
            @(negedge clk);
            n++;
        end
        check(0, "bp_reach_done", int'(out_valid[0]), 1);
        repeat (3) begin
            @(negedge clk);
            #1;
            check(0, "bp_in_ready", int'(in_ready[0]), 0);
            check(0, "bp_out_valid", int'(out_valid[0]), 1);
            check(0, "bp_out_x", int'(out_x[0]), 11);
            check(0, "bp_out_sat", int'(out_sat[0]), 1);
        end
        rmode[0] = 2;
        @(negedge clk);
        @(negedge clk);
        #1;
        check(0, "bp_idle_in_ready", int'(in_ready[0]), 1);
        check(0, "bp_idle_out_valid", int'(out_valid[0]), 0);
        rmode[0] = 0;
        drain();

        send(0, 4'b0000, 4'b0000);
        @(negedge clk);
        #2 rst_n[0] = 1'b0;
        #1;
        check(0, "midrst_out_valid", int'(out_valid[0]), 0);
        check(0, "midrst_out_x", int'(out_x[0]), 0);
        check(0, "midrst_out_sat", int'(out_sat[0]), 0);
        @(negedge clk);
        #2 rst_n[0] = 1'b1;
        #1;
        check(0, "midrst_in_ready", int'(in_ready[0]), 1);
        send(0, 4'b0000, 4'b0000);
        drain();

        for (int i = 0; i < 60; i++) send(int'($urandom % 2), W'($urandom), W'($urandom));
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
